// File: rtl/chan_wr_ctl.sv
// chan_wr_ctl
//   Routes bytes from the SPI byte receiver. Command bytes (dc_i=0) select a
//   mode. The data bytes that follow (dc_i=1) become one of:
//     - config register writes,
//     - address-table writes,
//     - colour-RAM writes,
//     - info-register read address steps,
//     - a window selection (start channel / start address) for partial updates.
//
// Ports
//   clk_i, rst_n_i     clock, asynchronous active-low reset
//   dc_i               0 = command byte, 1 = data byte
//   spi_byte_vld_i     one-cycle byte strobe; all state updates are gated by it
//   spi_byte_data_i    received byte
//   reg_chan_len_i     last RAM address per channel (inclusive)
//   reg_chan_cnt_i     index of the last active channel
//   reg_rd_addr_o      info/register read address
//   reg_wr_en_o        config register write strobe (combinational)
//   reg_wr_addr_o      config register write address
//   ram_wr_en_o        per-channel RAM write strobe, one-hot or zero (combinational)
//   ram_wr_done_o      final colour byte of a frame is being written
//   ram_wr_addr_o      RAM write address
//   ram_wr_byte_en_o   lane enables: MSB = address-table lane, [COLOR_BYTES-1:0] = colour lanes
//   ovf_o              sticky: data byte after frame end or with an invalid window
module chan_wr_ctl #(
  parameter int unsigned CHAN_NUM    = 16,
  parameter int unsigned COLOR_BYTES = 3,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned REG_AW      = 3,
  parameter int unsigned CH_W        = $clog2(CHAN_NUM)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   dc_i,
  input  logic                   spi_byte_vld_i,
  input  logic [7:0]             spi_byte_data_i,
  input  logic [ADDR_W-1:0]      reg_chan_len_i,
  input  logic [CH_W-1:0]        reg_chan_cnt_i,
  output logic [REG_AW-1:0]      reg_rd_addr_o,
  output logic                   reg_wr_en_o,
  output logic [REG_AW-1:0]      reg_wr_addr_o,
  output logic [CHAN_NUM-1:0]    ram_wr_en_o,
  output logic                   ram_wr_done_o,
  output logic [ADDR_W-1:0]      ram_wr_addr_o,
  output logic [COLOR_BYTES:0]   ram_wr_byte_en_o,
  output logic                   ovf_o
);

  localparam int unsigned     LANE_W   = (COLOR_BYTES > 1) ? $clog2(COLOR_BYTES) : 1;
  localparam logic [LANE_W-1:0] LANE_TOP = LANE_W'(COLOR_BYTES - 1);
  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(CHAN_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CONF, S_ADDR, S_DATA, S_INFO, S_SEL0, S_SEL1, S_DONE
  } state_t;

  state_t              state_q;
  logic [CH_W-1:0]     cur_ch_q;
  logic [CH_W-1:0]     start_ch_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   start_addr_q;
  logic [LANE_W-1:0]   lane_q;
  logic [REG_AW-1:0]   rd_addr_q;
  logic [REG_AW-1:0]   wr_addr_q;
  logic                ovf_q;

  logic data_byte;
  logic ram_act;
  logic addr_last;
  logic frame_last;
  logic step;
  logic win_bad;

  always_comb begin
    data_byte  = spi_byte_vld_i && dc_i;
    ram_act    = data_byte && ((state_q == S_ADDR) || (state_q == S_DATA));
    addr_last  = (addr_q == reg_chan_len_i);
    frame_last = addr_last && (cur_ch_q == reg_chan_cnt_i);
    // Address/channel advance: every address-table byte, or the last lane of a pixel.
    step       = (state_q == S_ADDR) || ((state_q == S_DATA) && (lane_q == '0));
    win_bad    = (start_ch_q > reg_chan_cnt_i) || (start_addr_q > reg_chan_len_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      cur_ch_q     <= '0;
      start_ch_q   <= '0;
      addr_q       <= '0;
      start_addr_q <= '0;
      lane_q       <= '0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      ovf_q        <= 1'b0;
    end else if (spi_byte_vld_i) begin
      if (!dc_i) begin
        ovf_q     <= 1'b0;
        addr_q    <= '0;
        wr_addr_q <= '0;
        case (spi_byte_data_i)
          8'h2A: state_q <= S_CONF;
          8'h2B, 8'h2C: begin
            cur_ch_q <= start_ch_q;
            addr_q   <= start_addr_q;
            lane_q   <= LANE_TOP;
            // An out-of-range window is parked in DONE so no write can escape.
            if (win_bad)
              state_q <= S_DONE;
            else if (spi_byte_data_i == 8'h2C)
              state_q <= S_DATA;
            else
              state_q <= S_ADDR;
          end
          8'h3A: begin
            state_q   <= S_INFO;
            rd_addr_q <= REG_AW'(1);
          end
          8'h2D: state_q <= S_SEL0;
          default: begin
            state_q   <= S_IDLE;
            rd_addr_q <= '0;
          end
        endcase
      end else begin
        case (state_q)
          S_CONF: wr_addr_q <= wr_addr_q + REG_AW'(1);
          S_INFO: rd_addr_q <= rd_addr_q + REG_AW'(1);
          S_SEL0: begin
            start_ch_q <= spi_byte_data_i[CH_W-1:0];
            state_q    <= S_SEL1;
          end
          S_SEL1: begin
            start_addr_q <= spi_byte_data_i[ADDR_W-1:0];
            state_q      <= S_IDLE;
          end
          S_DATA: lane_q <= (lane_q == '0) ? LANE_TOP : lane_q - LANE_W'(1);
          S_DONE: ovf_q <= 1'b1;
          default: ;
        endcase
        // Channel index wraps at CHAN_NUM so a live change of reg_chan_cnt_i
        // below cur_ch still reaches the last channel and ends the frame.
        if (step) begin
          if (addr_last) begin
            addr_q   <= '0;
            cur_ch_q <= (cur_ch_q == CH_LAST) ? '0 : cur_ch_q + CH_W'(1);
            if (frame_last)
              state_q <= S_DONE;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    reg_wr_en_o      = data_byte && (state_q == S_CONF);
    ram_wr_done_o    = data_byte && (state_q == S_DATA) && (lane_q == '0) && frame_last;
    ram_wr_byte_en_o = '0;
    if (data_byte && (state_q == S_ADDR))
      ram_wr_byte_en_o[COLOR_BYTES] = 1'b1;
    if (data_byte && (state_q == S_DATA))
      ram_wr_byte_en_o[lane_q] = 1'b1;
    for (int unsigned i = 0; i < CHAN_NUM; i++)
      ram_wr_en_o[i] = ram_act && (cur_ch_q == CH_W'(i));
  end

  assign reg_rd_addr_o = rd_addr_q;
  assign reg_wr_addr_o = wr_addr_q;
  assign ram_wr_addr_o = addr_q;
  assign ovf_o         = ovf_q;

endmodule

// File: tb/tb_chan_wr_ctl.sv
module tb_chan_wr_ctl;

  localparam int unsigned CHAN_NUM    = 16;
  localparam int unsigned COLOR_BYTES = 3;
  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned REG_AW      = 3;
  localparam int unsigned CH_W        = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_n_i = 1'b0;
  logic                 dc_i = 1'b0;
  logic                 spi_byte_vld_i = 1'b0;
  logic [7:0]           spi_byte_data_i = '0;
  logic [ADDR_W-1:0]    reg_chan_len_i = '0;
  logic [CH_W-1:0]      reg_chan_cnt_i = '0;
  logic [REG_AW-1:0]    reg_rd_addr_o;
  logic                 reg_wr_en_o;
  logic [REG_AW-1:0]    reg_wr_addr_o;
  logic [CHAN_NUM-1:0]  ram_wr_en_o;
  logic                 ram_wr_done_o;
  logic [ADDR_W-1:0]    ram_wr_addr_o;
  logic [COLOR_BYTES:0] ram_wr_byte_en_o;
  logic                 ovf_o;

  chan_wr_ctl #(
    .CHAN_NUM(CHAN_NUM), .COLOR_BYTES(COLOR_BYTES), .ADDR_W(ADDR_W),
    .REG_AW(REG_AW), .CH_W(CH_W)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .dc_i(dc_i),
    .spi_byte_vld_i(spi_byte_vld_i), .spi_byte_data_i(spi_byte_data_i),
    .reg_chan_len_i(reg_chan_len_i), .reg_chan_cnt_i(reg_chan_cnt_i),
    .reg_rd_addr_o(reg_rd_addr_o), .reg_wr_en_o(reg_wr_en_o),
    .reg_wr_addr_o(reg_wr_addr_o), .ram_wr_en_o(ram_wr_en_o),
    .ram_wr_done_o(ram_wr_done_o), .ram_wr_addr_o(ram_wr_addr_o),
    .ram_wr_byte_en_o(ram_wr_byte_en_o), .ovf_o(ovf_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: modes and a precomputed list of the writes a frame owes.
  localparam int M_IDLE = 0, M_CONF = 1, M_INFO = 2, M_SEL0 = 3, M_SEL1 = 4, M_FRAME = 5;

  typedef struct {
    int ch;
    int addr;
    int be;
    bit done;
  } wr_t;

  wr_t frame_q[$];
  int  m_mode, m_start_ch, m_start_addr, m_rd, m_wr;
  bit  m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_start_ch = 0; m_start_addr = 0;
    m_rd = 0; m_wr = 0; m_ovf = 0;
    frame_q.delete();
  endtask

  task automatic build_frame(input bit data_mode);
    int cnt, len;
    wr_t w;
    cnt = int'(reg_chan_cnt_i);
    len = int'(reg_chan_len_i);
    frame_q.delete();
    if (m_start_ch <= cnt && m_start_addr <= len) begin
      for (int ch = m_start_ch; ch <= cnt; ch++)
        for (int a = (ch == m_start_ch) ? m_start_addr : 0; a <= len; a++) begin
          if (!data_mode) begin
            w.ch = ch; w.addr = a; w.be = 1 << COLOR_BYTES; w.done = 0;
            frame_q.push_back(w);
          end else begin
            for (int l = COLOR_BYTES - 1; l >= 0; l--) begin
              w.ch = ch; w.addr = a; w.be = 1 << l; w.done = 0;
              frame_q.push_back(w);
            end
          end
        end
      if (data_mode) frame_q[frame_q.size()-1].done = 1;
    end
  endtask

  task automatic send(input bit dc, input logic [7:0] b);
    logic [31:0] e_ram_en;
    int e_be;
    bit e_reg_wr, e_done;
    @(negedge clk_i);
    dc_i = dc; spi_byte_data_i = b; spi_byte_vld_i = 1'b1;
    #1;
    if (dc) begin
      e_ram_en = '0; e_be = 0; e_reg_wr = 0; e_done = 0;
      if (m_mode == M_CONF) begin
        e_reg_wr = 1;
        chk("reg_wr_addr", 32'(reg_wr_addr_o), 32'(m_wr));
      end else if (m_mode == M_FRAME && frame_q.size() > 0) begin
        e_ram_en = 32'(1) << frame_q[0].ch;
        e_be     = frame_q[0].be;
        e_done   = frame_q[0].done;
        chk("ram_wr_addr", 32'(ram_wr_addr_o), 32'(frame_q[0].addr));
      end
      chk("reg_wr_en", 32'(reg_wr_en_o), 32'(e_reg_wr));
      chk("ram_wr_en", 32'(ram_wr_en_o), e_ram_en);
      chk("byte_en", 32'(ram_wr_byte_en_o), 32'(e_be));
      chk("wr_done", 32'(ram_wr_done_o), 32'(e_done));
    end
    @(posedge clk_i);
    #1;
    spi_byte_vld_i = 1'b0; dc_i = 1'b0;
    if (!dc) begin
      m_ovf = 0; m_wr = 0;
      case (b)
        8'h2A: m_mode = M_CONF;
        8'h2B: begin m_mode = M_FRAME; build_frame(0); end
        8'h2C: begin m_mode = M_FRAME; build_frame(1); end
        8'h3A: begin m_mode = M_INFO; m_rd = 1; end
        8'h2D: m_mode = M_SEL0;
        default: begin m_mode = M_IDLE; m_rd = 0; end
      endcase
    end else begin
      case (m_mode)
        M_CONF: m_wr = (m_wr + 1) % (1 << REG_AW);
        M_INFO: m_rd = (m_rd + 1) % (1 << REG_AW);
        M_SEL0: begin m_start_ch = int'(b) % (1 << CH_W); m_mode = M_SEL1; end
        M_SEL1: begin m_start_addr = int'(b) % (1 << ADDR_W); m_mode = M_IDLE; end
        M_FRAME: if (frame_q.size() > 0) void'(frame_q.pop_front()); else m_ovf = 1;
        default: ;
      endcase
    end
    chk("ovf", 32'(ovf_o), 32'(m_ovf));
    chk("reg_rd_addr", 32'(reg_rd_addr_o), 32'(m_rd));
    chk("reg_wr_addr_q", 32'(reg_wr_addr_o), 32'(m_wr));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ram_en"}, 32'(ram_wr_en_o), 32'd0);
    chk({tag, "_reg_wr_en"}, 32'(reg_wr_en_o), 32'd0);
    chk({tag, "_done"}, 32'(ram_wr_done_o), 32'd0);
    chk({tag, "_be"}, 32'(ram_wr_byte_en_o), 32'd0);
    chk({tag, "_ram_addr"}, 32'(ram_wr_addr_o), 32'd0);
    chk({tag, "_rd_addr"}, 32'(reg_rd_addr_o), 32'd0);
    chk({tag, "_wr_addr"}, 32'(reg_wr_addr_o), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf_o), 32'd0);
  endtask

  // Asynchronous reset asserted mid-cycle while a data byte is being presented.
  task automatic pulse_reset(input string tag);
    @(negedge clk_i);
    dc_i = 1'b1; spi_byte_data_i = 8'h55; spi_byte_vld_i = 1'b1;
    #2 rst_n_i = 1'b0;
    #1 check_all_zero(tag);
    @(negedge clk_i);
    spi_byte_vld_i = 1'b0; dc_i = 1'b0;
    rst_n_i = 1'b1;
    model_reset();
  endtask

  initial begin
    int r;
    logic [7:0] cmds [6];
    model_reset();
    cmds[0] = 8'h2A; cmds[1] = 8'h2B; cmds[2] = 8'h2C;
    cmds[3] = 8'h3A; cmds[4] = 8'h2D; cmds[5] = 8'h00;

    #12;
    check_all_zero("reset");
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Full colour frame, two channels of two pixels, plus one overflow byte.
    reg_chan_cnt_i = 4'd1; reg_chan_len_i = 8'd1;
    send(0, 8'h2C);
    for (int i = 0; i < 13; i++) send(1, 8'(i));

    // Window ch3/addr2, address-table writes.
    send(0, 8'h2D); send(1, 8'h03); send(1, 8'h02);
    reg_chan_cnt_i = 4'd3; reg_chan_len_i = 8'd3;
    send(0, 8'h2B);
    for (int i = 0; i < 3; i++) send(1, 8'hA0);

    // Config writes with wrap, info reads.
    send(0, 8'h2A);
    for (int i = 0; i < 9; i++) send(1, 8'(i * 7));
    send(0, 8'h3A);
    for (int i = 0; i < 3; i++) send(1, 8'h11);

    // Restart a colour frame mid-way, then abort by reset mid-frame.
    send(0, 8'h2D); send(1, 8'h00); send(1, 8'h00);
    reg_chan_cnt_i = 4'd1; reg_chan_len_i = 8'd1;
    send(0, 8'h2C);
    for (int i = 0; i < 5; i++) send(1, 8'h33);
    send(0, 8'h2C);
    for (int i = 0; i < 3; i++) send(1, 8'h44);
    pulse_reset("midrst");

    // Invalid window: start channel beyond last active channel.
    send(0, 8'h2D); send(1, 8'h05); send(1, 8'h00);
    reg_chan_cnt_i = 4'd2;
    send(0, 8'h2C);
    send(1, 8'h77);

    // Randomised traffic; geometry changes only alongside a command byte.
    for (int n = 0; n < 500; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7) begin
        if ($urandom_range(0, 1) == 0) send(1, 8'($urandom_range(0, 4)));
        else send(1, 8'($urandom_range(0, 255)));
      end else begin
        reg_chan_cnt_i = 4'($urandom_range(0, 3));
        reg_chan_len_i = 8'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) send(0, 8'($urandom_range(0, 255)));
        else send(0, cmds[$urandom_range(0, 5)]);
      end
    end
    pulse_reset("endrst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/chan_wr_ctl.md
Name: chan_wr_ctl

Overview:
- Parametrised SPI command/data router between the SPI byte receiver and the per-channel pixel RAMs and the config register file.
- Decodes command bytes (dc_i=0) and steers the data bytes that follow (dc_i=1) to register writes, address-table writes, colour-RAM writes or info reads.
- Generalised in channel count, colour bytes per pixel and RAM depth.
- Adds a window-select command for partial updates and a sticky overflow flag.

Parameters:
CHAN_NUM, 16, number of output channels (2..32)
COLOR_BYTES, 3, bytes per pixel (3 = RGB, 4 = RGBW)
ADDR_W, 8, RAM address width per channel (<= 8)
REG_AW, 3, config register address width
CH_W, $clog2(CHAN_NUM), channel index width (derived)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
dc_i  in  1  0 = command byte, 1 = data byte
spi_byte_vld_i  in  1  one-cycle strobe, byte valid
spi_byte_data_i  in  8  received byte
reg_chan_len_i  in  ADDR_W  last RAM address per channel (inclusive)
reg_chan_cnt_i  in  CH_W  index of last active channel
reg_rd_addr_o  out  REG_AW  info/register read address
reg_wr_en_o  out  1  config register write strobe
reg_wr_addr_o  out  REG_AW  config register write address
ram_wr_en_o  out  CHAN_NUM  per-channel RAM write strobe (one-hot or 0)
ram_wr_done_o  out  1  final colour byte of a frame written
ram_wr_addr_o  out  ADDR_W  RAM write address
ram_wr_byte_en_o  out  COLOR_BYTES+1  lane enable; MSB = address-table lane, [COLOR_BYTES-1:0] = colour lanes
ovf_o  out  1  sticky: data byte arrived after frame end or with an invalid window

Behaviour:
- Reset (async, rst_n_i=0): state IDLE; all counters, start_ch and start_addr = 0; every output = 0.
- All state updates occur only on cycles with spi_byte_vld_i=1.
- Write strobes are combinational with spi_byte_vld_i (zero latency):
  - reg_wr_en_o = vld & CONF.
  - ram_wr_en_o[ch] = vld & (ADDR|DATA) & (ch == cur_ch).
  - ram_wr_done_o = vld & DATA & lane0 & (addr == reg_chan_len_i) & (cur_ch == reg_chan_cnt_i).
- Command bytes (dc_i=0) are accepted in every state. Each command clears ovf_o and sets the write address to 0, except as noted:
  - 0x2A → CONF.
  - 0x2B → ADDR: cur_ch = start_ch, addr = start_addr.
  - 0x2C → DATA: as ADDR, lane = COLOR_BYTES-1.
  - 0x3A → INFO: reg_rd_addr_o = 1.
  - 0x2D → SEL0.
  - Any other byte → IDLE, reg_rd_addr_o = 0.
- Data-byte behaviour (dc_i=1) by state:
  - IDLE: byte ignored.
  - CONF: write at reg_wr_addr_o, then increment modulo 2^REG_AW; no end.
  - INFO: reg_rd_addr_o increments per byte, wrapping modulo 2^REG_AW.
  - SEL0: start_ch = byte[CH_W-1:0] → SEL1.
  - SEL1: start_addr = byte[ADDR_W-1:0] → IDLE.
  - The window persists until the next SEL or reset.
  - ADDR:
    - ram_wr_byte_en_o = MSB only.
    - Write at addr; addr++. At addr == reg_chan_len_i, addr → 0 and cur_ch++.
    - After the last byte of channel reg_chan_cnt_i → DONE.
  - DATA:
    - ram_wr_byte_en_o one-hot at lane; lanes go MSB-first, COLOR_BYTES-1 down to 0.
    - After lane 0: lane reloads to COLOR_BYTES-1 and addr advances as in ADDR.
    - After the final byte of the frame → DONE.
  - DONE: bytes ignored, strobes 0, ovf_o = 1.
- Invalid window: on 0x2B/0x2C with start_ch > reg_chan_cnt_i or start_addr > reg_chan_len_i, go to DONE and emit no writes; the first data byte sets ovf_o.
- reg_chan_len_i and reg_chan_cnt_i are sampled live; changing them mid-frame is unsupported, and the design must not hang (DONE is still reached via cur_ch wrap).
- Reset mid-frame aborts immediately; no done pulse.

Test Plan:
- CMD 0x2C, cnt=1, len=1, COLOR_BYTES=3, 12 data bytes:
  - ram_wr_en_o = 0x0001 for bytes 1-6, 0x0002 for bytes 7-12.
  - Addresses 0,0,0,1,1,1 repeat per channel; lanes 4,2,1 per pixel.
  - ram_wr_done_o high only on byte 12.
  - 13th byte: no strobe, ovf_o = 1.
- CMD 0x2D, data 0x03, 0x02; then 0x2B, cnt=3, len=3:
  - First write: ch3 / addr2, byte_en 0x8.
  - Second write: ch3 / addr3.
  - Third byte: ignored, ovf_o = 1.
- CMD 0x2A, 9 data bytes: reg_wr_en_o on each; reg_wr_addr_o = 0..7, then 0.
- CMD 0x3A, 3 data bytes: reg_rd_addr_o = 1 → 2 → 3 → 4; no write strobes.
- Mid-DATA command 0x2C after 5 bytes: restarts at start window, lane MSB; ovf_o cleared. Repeat with rst_n_i pulse: all outputs 0 asynchronously.
- Window start_ch=5 with cnt=2, then 0x2C and 1 data byte: zero writes, ovf_o = 1.
